// File: rtl/branch_repair_if.sv
// Request, redirect and predictor-update signals between the repair unit and its neighbours.
// master = requesters/consumers (exception unit, amend stages, predictor); slave = repair unit.
interface branch_repair_if #(
  parameter int CKPT_W   = 32,
  parameter int REPAIR_W = 4
);
  logic                exc_valid_i;
  logic [31:0]         exc_target_i;
  logic                sba_flush_i;
  logic [31:0]         sba_vaddr_i;
  logic [31:0]         sba_dest_i;
  logic                sba_take_i;
  logic [CKPT_W-1:0]   sba_ckpt_i;
  logic [REPAIR_W-1:0] sba_action_i;
  logic                fba_flush_i;
  logic [31:0]         fba_vaddr_i;
  logic [31:0]         fba_dest_i;
  logic                fba_take_i;
  logic [CKPT_W-1:0]   fba_ckpt_i;
  logic [REPAIR_W-1:0] fba_action_i;
  logic                redirect_valid_o;
  logic [31:0]         redirect_pc_o;
  logic                ckpt_restore_o;
  logic [CKPT_W-1:0]   ckpt_o;
  logic                upd_valid_o;
  logic                upd_ready_i;
  logic [31:0]         upd_pc_o;
  logic [31:0]         upd_dest_o;
  logic                upd_take_o;
  logic                upd_btb_o;
  logic [7:0]          drop_cnt_o;
  logic                busy_o;

  modport master (
    output exc_valid_i, exc_target_i,
    output sba_flush_i, sba_vaddr_i, sba_dest_i, sba_take_i, sba_ckpt_i, sba_action_i,
    output fba_flush_i, fba_vaddr_i, fba_dest_i, fba_take_i, fba_ckpt_i, fba_action_i,
    output upd_ready_i,
    input  redirect_valid_o, redirect_pc_o, ckpt_restore_o, ckpt_o,
    input  upd_valid_o, upd_pc_o, upd_dest_o, upd_take_o, upd_btb_o,
    input  drop_cnt_o, busy_o
  );

  modport slave (
    input  exc_valid_i, exc_target_i,
    input  sba_flush_i, sba_vaddr_i, sba_dest_i, sba_take_i, sba_ckpt_i, sba_action_i,
    input  fba_flush_i, fba_vaddr_i, fba_dest_i, fba_take_i, fba_ckpt_i, fba_action_i,
    input  upd_ready_i,
    output redirect_valid_o, redirect_pc_o, ckpt_restore_o, ckpt_o,
    output upd_valid_o, upd_pc_o, upd_dest_o, upd_take_o, upd_btb_o,
    output drop_cnt_o, busy_o
  );
endinterface

// File: rtl/branch_repair_unit.sv
// Age-ordered arbiter for exception/branch-repair flushes: registered PC redirect, checkpoint
// restore, priority shadow after each redirect, and a predictor-update FIFO with drop counter.
module branch_repair_unit #(
  parameter int CKPT_W    = 32,
  parameter int REPAIR_W  = 4,
  parameter int UPD_DEPTH = 4,
  parameter int SHADOW    = 2
) (
  input  logic            clk,
  input  logic            rst,
  branch_repair_if.slave  bus
);
  localparam int PW = $clog2(UPD_DEPTH);
  localparam int CW = $clog2(UPD_DEPTH + 1);
  localparam logic [2:0] SHADOW_L = 3'(SHADOW);

  typedef enum logic [1:0] {IDLE, REDIR, SHAD} state_t;
  typedef enum logic [1:0] {LV_NONE, LV_FBA, LV_SBA, LV_EXC} lvl_t;

  typedef struct packed {
    logic [31:0]         vaddr;
    logic [31:0]         dest;
    logic                take;
    logic [CKPT_W-1:0]   ckpt;
    logic [REPAIR_W-1:0] action;
  } br_req_t;

  state_t            state;
  lvl_t              lvl;
  logic [2:0]        shd_cnt;
  logic              redirect_valid_q, ckpt_restore_q;
  logic [31:0]       redirect_pc_q;
  logic [CKPT_W-1:0] ckpt_q;

  br_req_t sba, fba, br;
  logic    exc_req, sba_req, fba_req;
  logic    win_exc, win_sba, win_fba, any_win, push_req;
  logic [31:0] br_pc;

  assign sba = '{bus.sba_vaddr_i, bus.sba_dest_i, bus.sba_take_i, bus.sba_ckpt_i, bus.sba_action_i};
  assign fba = '{bus.fba_vaddr_i, bus.fba_dest_i, bus.fba_take_i, bus.fba_ckpt_i, bus.fba_action_i};

  // lvl is NONE whenever the FSM is idle, so one compare covers both idle and shadow cases
  assign exc_req = bus.exc_valid_i && (lvl < LV_EXC);
  assign sba_req = bus.sba_flush_i && sba.action[0] && (lvl < LV_SBA);
  assign fba_req = bus.fba_flush_i && fba.action[0] && (lvl < LV_FBA);

  assign win_exc = exc_req;
  assign win_sba = !exc_req && sba_req;
  assign win_fba = !exc_req && !sba_req && fba_req;
  assign any_win = win_exc || win_sba || win_fba;

  assign br       = win_sba ? sba : fba;
  assign br_pc    = br.take ? br.dest : br.vaddr + 32'd8;
  assign push_req = (win_sba || win_fba) && (br.action[2] || br.action[3]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      lvl              <= LV_NONE;
      shd_cnt          <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      ckpt_restore_q   <= 1'b0;
      ckpt_q           <= '0;
    end else begin
      redirect_valid_q <= any_win;
      ckpt_restore_q   <= any_win && !win_exc && br.action[1];
      if (any_win) begin
        state         <= REDIR;
        redirect_pc_q <= win_exc ? bus.exc_target_i : br_pc;
        lvl           <= win_exc ? LV_EXC : (win_sba ? LV_SBA : LV_FBA);
        if (!win_exc && br.action[1]) ckpt_q <= br.ckpt;
      end else begin
        case (state)
          REDIR: begin
            if (SHADOW == 0) begin
              state <= IDLE;
              lvl   <= LV_NONE;
            end else begin
              state   <= SHAD;
              shd_cnt <= SHADOW_L;
            end
          end
          SHAD: begin
            if (shd_cnt <= 3'd1) begin
              state <= IDLE;
              lvl   <= LV_NONE;
            end else begin
              shd_cnt <= shd_cnt - 3'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.redirect_valid_o = redirect_valid_q;
  assign bus.redirect_pc_o    = redirect_pc_q;
  assign bus.ckpt_restore_o   = ckpt_restore_q;
  assign bus.ckpt_o           = ckpt_q;
  assign bus.busy_o           = (state != IDLE);

  // Predictor-update FIFO
  logic [31:0] pc_mem   [UPD_DEPTH];
  logic [31:0] dest_mem [UPD_DEPTH];
  logic        take_mem [UPD_DEPTH];
  logic        btb_mem  [UPD_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic [7:0]    drop_cnt;
  logic empty, full, pop, push, drop;

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(UPD_DEPTH));
  assign pop   = !empty && bus.upd_ready_i;
  // a full FIFO still takes a push when the head leaves in the same cycle
  assign push  = push_req && (!full || pop);
  assign drop  = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= br.vaddr;
      dest_mem[wr_ptr] <= br.dest;
      take_mem[wr_ptr] <= br.take;
      btb_mem[wr_ptr]  <= br.action[3];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      cnt <= cnt + CW'(1);
      else if (pop && !push) cnt <= cnt - CW'(1);
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign bus.upd_valid_o = !empty;
  assign bus.upd_pc_o    = empty ? '0   : pc_mem[rd_ptr];
  assign bus.upd_dest_o  = empty ? '0   : dest_mem[rd_ptr];
  assign bus.upd_take_o  = empty ? 1'b0 : take_mem[rd_ptr];
  assign bus.upd_btb_o   = empty ? 1'b0 : btb_mem[rd_ptr];
  assign bus.drop_cnt_o  = drop_cnt;
endmodule

// File: tb/tb_branch_repair_unit.sv
// Directed bench for branch_repair_unit: redirect targets, priority, shadow, FIFO full/drain, reset.
module tb_branch_repair_unit;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  branch_repair_if #(.CKPT_W(32), .REPAIR_W(4)) bus ();

  branch_repair_unit #(.CKPT_W(32), .REPAIR_W(4), .UPD_DEPTH(4), .SHADOW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_req();
    bus.exc_valid_i  = 1'b0; bus.exc_target_i = '0;
    bus.sba_flush_i  = 1'b0; bus.sba_vaddr_i = '0; bus.sba_dest_i = '0;
    bus.sba_take_i   = 1'b0; bus.sba_ckpt_i  = '0; bus.sba_action_i = '0;
    bus.fba_flush_i  = 1'b0; bus.fba_vaddr_i = '0; bus.fba_dest_i = '0;
    bus.fba_take_i   = 1'b0; bus.fba_ckpt_i  = '0; bus.fba_action_i = '0;
  endtask

  task automatic drive_sba(input logic [31:0] va, input logic [31:0] de, input logic tk,
                           input logic [3:0] act, input logic [31:0] ck);
    bus.sba_flush_i = 1'b1; bus.sba_vaddr_i = va; bus.sba_dest_i = de;
    bus.sba_take_i  = tk;   bus.sba_action_i = act; bus.sba_ckpt_i = ck;
  endtask

  task automatic drive_fba(input logic [31:0] va, input logic [31:0] de, input logic tk,
                           input logic [3:0] act, input logic [31:0] ck);
    bus.fba_flush_i = 1'b1; bus.fba_vaddr_i = va; bus.fba_dest_i = de;
    bus.fba_take_i  = tk;   bus.fba_action_i = act; bus.fba_ckpt_i = ck;
  endtask

  // one-cycle sba request from idle, then enough quiet cycles for the shadow to expire
  task automatic push_sba(input logic [31:0] va, input logic [31:0] de, input logic tk,
                          input logic [3:0] act);
    drive_sba(va, de, tk, act, 32'h0);
    step();
    clear_req();
    repeat (5) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] iv;
    clear_req();
    bus.upd_ready_i = 1'b0;
    rst = 1'b1;
    step(); step();

    // reset state
    chk("rst_redir_valid", 32'(bus.redirect_valid_o), 32'd0);
    chk("rst_redir_pc",    bus.redirect_pc_o,          32'd0);
    chk("rst_ckpt_rest",   32'(bus.ckpt_restore_o),   32'd0);
    chk("rst_upd_valid",   32'(bus.upd_valid_o),      32'd0);
    chk("rst_busy",        32'(bus.busy_o),           32'd0);
    chk("rst_drop",        32'(bus.drop_cnt_o),       32'd0);
    rst = 1'b0;
    step();

    // basic taken redirect with checkpoint and push
    drive_sba(32'h1000, 32'h2000, 1'b1, 4'b0111, 32'hCAFE_0001);
    step();
    clear_req();
    chk("basic_valid",     32'(bus.redirect_valid_o), 32'd1);
    chk("basic_pc",        bus.redirect_pc_o,          32'h2000);
    chk("basic_ckpt_rest", 32'(bus.ckpt_restore_o),   32'd1);
    chk("basic_ckpt",      bus.ckpt_o,                 32'hCAFE_0001);
    chk("basic_busy",      32'(bus.busy_o),           32'd1);
    chk("basic_upd_valid", 32'(bus.upd_valid_o),      32'd1);
    chk("basic_upd_pc",    bus.upd_pc_o,               32'h1000);
    chk("basic_upd_dest",  bus.upd_dest_o,             32'h2000);
    chk("basic_upd_take",  32'(bus.upd_take_o),       32'd1);
    chk("basic_upd_btb",   32'(bus.upd_btb_o),        32'd0);
    step();
    chk("basic_pulse_end", 32'(bus.redirect_valid_o), 32'd0);
    chk("basic_ckpt_end",  32'(bus.ckpt_restore_o),   32'd0);
    bus.upd_ready_i = 1'b1;
    step();
    bus.upd_ready_i = 1'b0;
    chk("basic_drained",   32'(bus.upd_valid_o),      32'd0);
    repeat (4) step();
    chk("basic_idle",      32'(bus.busy_o),           32'd0);

    // not-taken fba: fall through past the delay slot, no restore, no push
    drive_fba(32'hBFC0_0010, 32'h0, 1'b0, 4'b0001, 32'h0);
    step();
    clear_req();
    chk("nt_valid",        32'(bus.redirect_valid_o), 32'd1);
    chk("nt_pc",           bus.redirect_pc_o,          32'hBFC0_0018);
    chk("nt_ckpt_rest",    32'(bus.ckpt_restore_o),   32'd0);
    chk("nt_no_push",      32'(bus.upd_valid_o),      32'd0);
    repeat (5) step();

    // all three at once: exception wins, then sba/fba blocked for two cycles
    bus.exc_valid_i = 1'b1; bus.exc_target_i = 32'hBFC0_0380;
    drive_sba(32'h3000, 32'h3100, 1'b1, 4'b0111, 32'h1111);
    drive_fba(32'h4000, 32'h4100, 1'b1, 4'b0111, 32'h2222);
    step();
    bus.exc_valid_i = 1'b0;
    chk("prio_valid",      32'(bus.redirect_valid_o), 32'd1);
    chk("prio_pc",         bus.redirect_pc_o,          32'hBFC0_0380);
    chk("prio_no_ckpt",    32'(bus.ckpt_restore_o),   32'd0);
    chk("prio_no_push",    32'(bus.upd_valid_o),      32'd0);
    step();
    chk("prio_blk1",       32'(bus.redirect_valid_o), 32'd0);
    chk("prio_busy",       32'(bus.busy_o),           32'd1);
    step();
    chk("prio_blk2",       32'(bus.redirect_valid_o), 32'd0);
    chk("prio_blk_nopush", 32'(bus.upd_valid_o),      32'd0);
    clear_req();
    repeat (5) step();

    // shadow levels: sba wins, fba blocked, exc breaks through the shadow
    drive_sba(32'h4000, 32'h5000, 1'b1, 4'b0001, 32'h0);
    step();
    clear_req();
    chk("shd_first_valid", 32'(bus.redirect_valid_o), 32'd1);
    chk("shd_first_pc",    bus.redirect_pc_o,          32'h5000);
    drive_fba(32'h6000, 32'h7000, 1'b1, 4'b0001, 32'h0);
    step();
    chk("shd_fba_blk",     32'(bus.redirect_valid_o), 32'd0);
    bus.exc_valid_i = 1'b1; bus.exc_target_i = 32'h8000_0180;
    step();
    clear_req();
    chk("shd_exc_valid",   32'(bus.redirect_valid_o), 32'd1);
    chk("shd_exc_pc",      bus.redirect_pc_o,          32'h8000_0180);
    step();
    chk("shd_exc_end",     32'(bus.redirect_valid_o), 32'd0);
    repeat (5) step();

    // FIFO full: six pushes with ready low, two dropped
    for (int i = 1; i <= 6; i++) begin
      iv = 32'(i);
      push_sba(32'h100 * iv, 32'h10000 + iv, iv[0], {iv[1], 1'b1, 1'b0, 1'b1});
    end
    chk("full_valid",      32'(bus.upd_valid_o),      32'd1);
    chk("full_drop",       32'(bus.drop_cnt_o),       32'd2);
    bus.upd_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      iv = 32'(i);
      chk($sformatf("drain_pc%0d", i),   bus.upd_pc_o,         32'h100 * iv);
      chk($sformatf("drain_dest%0d", i), bus.upd_dest_o,       32'h10000 + iv);
      chk($sformatf("drain_take%0d", i), 32'(bus.upd_take_o), 32'(iv[0]));
      chk($sformatf("drain_btb%0d", i),  32'(bus.upd_btb_o),  32'(iv[1]));
      step();
    end
    bus.upd_ready_i = 1'b0;
    chk("drain_empty",     32'(bus.upd_valid_o),      32'd0);

    // full with simultaneous push and pop: both honoured, nothing dropped
    for (int i = 1; i <= 4; i++) begin
      iv = 32'(i);
      push_sba(32'hA00 + iv, 32'hB00 + iv, 1'b1, 4'b0101);
    end
    bus.upd_ready_i = 1'b1;
    drive_sba(32'hA05, 32'hB05, 1'b1, 4'b0101, 32'h0);
    step();
    clear_req();
    bus.upd_ready_i = 1'b0;
    chk("pp_valid",        32'(bus.upd_valid_o),      32'd1);
    chk("pp_head",         bus.upd_pc_o,               32'hA02);
    chk("pp_drop",         32'(bus.drop_cnt_o),       32'd2);
    repeat (5) step();
    bus.upd_ready_i = 1'b1;
    for (int j = 2; j <= 5; j++) begin
      chk($sformatf("pp_drain%0d", j), bus.upd_pc_o, 32'hA00 + 32'(j));
      step();
    end
    bus.upd_ready_i = 1'b0;
    chk("pp_empty",        32'(bus.upd_valid_o),      32'd0);

    // reset during REDIR with three queued entries
    for (int i = 1; i <= 3; i++) push_sba(32'hC00 + 32'(i), 32'hC80, 1'b1, 4'b0101);
    drive_sba(32'hD000, 32'hE000, 1'b0, 4'b0001, 32'h0);
    step();
    clear_req();
    chk("mid_valid",       32'(bus.redirect_valid_o), 32'd1);
    chk("mid_pc",          bus.redirect_pc_o,          32'hD008);
    chk("mid_queued",      32'(bus.upd_valid_o),      32'd1);
    rst = 1'b1;
    step();
    chk("mid_rst_valid",   32'(bus.redirect_valid_o), 32'd0);
    chk("mid_rst_pc",      bus.redirect_pc_o,          32'd0);
    chk("mid_rst_ckpt",    bus.ckpt_o,                 32'd0);
    chk("mid_rst_upd",     32'(bus.upd_valid_o),      32'd0);
    chk("mid_rst_upd_pc",  bus.upd_pc_o,               32'd0);
    chk("mid_rst_busy",    32'(bus.busy_o),           32'd0);
    chk("mid_rst_drop",    32'(bus.drop_cnt_o),       32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_upd",    32'(bus.upd_valid_o),      32'd0);
    chk("post_rst_busy",   32'(bus.busy_o),           32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
